// File: rtl/pipeline_run_ctrl.sv
// Run-control sequencer for the 5-stage MIPS pipeline: run/step/drain/halt gating, halt kill, RF dump.
// Latency: every output is registered; an accepted command takes effect on the following cycle.
// Backpressure: o_cmd_ready drops outside IDLE/RUN/HALTED; dump beats hold until i_dump_ready. Option: RUN_CTRL_CYCLE_CNT_EN.
module pipeline_run_ctrl #(
    parameter int NUM_REGS     = 32,
    parameter int DRAIN_CYCLES = 4,
    localparam int AW          = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_cmd_valid,
    input  logic [1:0]    i_cmd,
    output logic          o_cmd_ready,
    input  logic          i_halt_detected,
    output logic          o_fetch_enable,
    output logic          o_pipe_enable,
    output logic          o_pipe_flush,
    output logic [AW-1:0] o_rf_dbg_addr,
    input  logic [31:0]   i_rf_dbg_data,
    output logic          o_dump_valid,
    output logic [31:0]   o_dump_data,
    output logic          o_dump_last,
    input  logic          i_dump_ready,
    output logic [2:0]    o_state,
    output logic [31:0]   o_cycle_count
);

    localparam int DCW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_REGS - 1);

    localparam logic [1:0] CMD_RUN  = 2'b00;
    localparam logic [1:0] CMD_STEP = 2'b01;
    localparam logic [1:0] CMD_DUMP = 2'b10;
    localparam logic [1:0] CMD_HALT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN       = 3'd1,
        ST_STEP      = 3'd2,
        ST_DRAIN     = 3'd3,
        ST_HALTED    = 3'd4,
        ST_DUMP_ADDR = 3'd5,
        ST_DUMP_SEND = 3'd6
    } state_t;

    state_t         state_q;
    state_t         state_n;
    logic [DCW-1:0] drain_q;
    logic [DCW-1:0] drain_n;
    logic           origin_halted_q;
    logic           origin_halted_n;
    logic [AW-1:0]  addr_n;
    logic           flush_n;
    logic           cmd_acc;

    logic           fetch_n;
    logic           pipe_n;
    logic           ready_n;
    logic           valid_n;
    logic           last_n;
    logic [31:0]    data_n;

    assign cmd_acc = i_cmd_valid && o_cmd_ready;
    assign o_state = state_q;

    always_comb begin
        state_n         = state_q;
        drain_n         = drain_q;
        origin_halted_n = origin_halted_q;
        addr_n          = o_rf_dbg_addr;
        flush_n         = 1'b0;

        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (cmd_acc) begin
                    case (i_cmd)
                        CMD_RUN:  state_n = ST_RUN;
                        CMD_STEP: state_n = ST_STEP;
                        CMD_DUMP: begin
                            state_n         = ST_DUMP_ADDR;
                            addr_n          = '0;
                            origin_halted_n = (state_q == ST_HALTED);
                        end
                        default: state_n = state_q;
                    endcase
                end
            end

            ST_RUN: begin
                // A retiring HALT beats a same-cycle HALT command: kill younger work, skip the drain.
                if (i_halt_detected) begin
                    state_n = ST_HALTED;
                    flush_n = 1'b1;
                end else if (cmd_acc && (i_cmd == CMD_HALT)) begin
                    state_n = ST_DRAIN;
                    drain_n = DCW'(DRAIN_CYCLES);
                end
            end

            ST_STEP: begin
                state_n = ST_HALTED;
                flush_n = i_halt_detected;
            end

            ST_DRAIN: begin
                if (i_halt_detected) begin
                    state_n = ST_HALTED;
                    flush_n = 1'b1;
                    drain_n = '0;
                end else if (drain_q <= DCW'(1)) begin
                    state_n = ST_HALTED;
                    drain_n = '0;
                end else begin
                    drain_n = drain_q - DCW'(1);
                end
            end

            ST_DUMP_ADDR: state_n = ST_DUMP_SEND;

            ST_DUMP_SEND: begin
                if (i_dump_ready) begin
                    if (o_dump_last) begin
                        state_n = origin_halted_q ? ST_HALTED : ST_IDLE;
                        addr_n  = '0;
                    end else begin
                        state_n = ST_DUMP_ADDR;
                        addr_n  = o_rf_dbg_addr + AW'(1);
                    end
                end
            end

            default: state_n = ST_IDLE;
        endcase
    end

    // Output flops are loaded from the next state so they line up with o_state.
    always_comb begin
        fetch_n = (state_n == ST_RUN) || (state_n == ST_STEP);
        pipe_n  = fetch_n || (state_n == ST_DRAIN);
        ready_n = (state_n == ST_IDLE) || (state_n == ST_RUN) || (state_n == ST_HALTED);
        valid_n = (state_n == ST_DUMP_SEND);
        last_n  = (state_n == ST_DUMP_SEND) && (addr_n == LAST_ADDR);
        data_n  = (state_q == ST_DUMP_ADDR) ? i_rf_dbg_data : o_dump_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            drain_q         <= '0;
            origin_halted_q <= 1'b0;
            o_rf_dbg_addr   <= '0;
            o_cmd_ready     <= 1'b0;
            o_fetch_enable  <= 1'b0;
            o_pipe_enable   <= 1'b0;
            o_pipe_flush    <= 1'b0;
            o_dump_valid    <= 1'b0;
            o_dump_last     <= 1'b0;
            o_dump_data     <= '0;
        end else begin
            state_q         <= state_n;
            drain_q         <= drain_n;
            origin_halted_q <= origin_halted_n;
            o_rf_dbg_addr   <= addr_n;
            o_cmd_ready     <= ready_n;
            o_fetch_enable  <= fetch_n;
            o_pipe_enable   <= pipe_n;
            o_pipe_flush    <= flush_n;
            o_dump_valid    <= valid_n;
            o_dump_last     <= last_n;
            o_dump_data     <= data_n;
        end
    end

`ifdef RUN_CTRL_CYCLE_CNT_EN
    logic [31:0] cycle_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt_q <= '0;
        end else if (o_pipe_enable && (cycle_cnt_q != 32'hFFFF_FFFF)) begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
        end
    end

    assign o_cycle_count = cycle_cnt_q;
`else
    assign o_cycle_count = 32'h0;
`endif

endmodule
